interrupt_responder: RTL and testbench
======================================

// Module: interrupt_responder
// PURPOSE
//  Core-side end of the interrupt request/acknowledge handshake. Accepts irq_req/irq_number from the
//  interrupt controller at an instruction boundary, saves the return PC and redirects fetch to the vector.
//  It pulses ack_attended on entry and ack_complete when the return-from-interrupt instruction retires.
//  Sits between the interrupt controller outputs and the core fetch/retire stage. Single level, no nesting.
// PARAMETERS
//  ADDR_W        32            PC/vector width
//  IRQ_W         2             irq number width (4 sources)
//  VECTOR_BASE   32'h0000_0100 address of vector 0
//  VECTOR_STRIDE 16            bytes between consecutive vectors
// PORTS
//  i_Clk          in   1       clock; single clock domain
//  i_Rst          in   1       synchronous, active-high reset
//  i_IrqReq       in   1       interrupt request, level, held by controller until ack_attended
//  i_IrqNumber    in   IRQ_W   number of the requesting source; valid while i_IrqReq=1
//  i_CoreIntEn    in   1       core global interrupt enable (status bit)
//  i_InstrBoundary in  1       an instruction retires this cycle; safe point to take an interrupt
//  i_NextPc       in   ADDR_W  PC of the next instruction; valid with i_InstrBoundary
//  i_RetiExec     in   1       return-from-interrupt instruction retires this cycle
//  o_AckAttended  out  1       1-cycle pulse: interrupt accepted (to controller ack_attended)
//  o_AckComplete  out  1       1-cycle pulse: handler finished (to controller ack_complete)
//  o_Redirect     out  1       1-cycle pulse: fetch must load o_RedirectPc
//  o_RedirectPc   out  ADDR_W  vector address on entry, saved PC on return
//  o_InHandler    out  1       level: handler running
//  o_ActiveIrq    out  IRQ_W   irq number being serviced; held until return
//  o_Err          out  1       1-cycle pulse: i_RetiExec outside a handler
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; saved PC 0. Reset mid-handler discards context; no ack_complete.
//  All outputs registered. Pulses last exactly one cycle.
//  States: IDLE, WAIT_BND, IN_HANDLER. RETURN is folded into the IN_HANDLER->IDLE edge.
//  IDLE: condition take = i_IrqReq & i_CoreIntEn.
//   take & i_InstrBoundary -> accept (below).
//   take & !i_InstrBoundary -> WAIT_BND.
//  WAIT_BND:
//   !i_IrqReq | !i_CoreIntEn -> IDLE; request withdrawn, no ack.
//   else if i_InstrBoundary -> accept.
//  accept (registered at that edge):
//   savedPc<=i_NextPc; o_ActiveIrq<=i_IrqNumber (sampled at this edge only);
//   o_RedirectPc<=VECTOR_BASE+i_IrqNumber*VECTOR_STRIDE (mod 2^ADDR_W);
//   o_Redirect=1 and o_AckAttended=1; o_InHandler<=1; -> IN_HANDLER.
//   Latency: 1 cycle from the qualifying boundary edge to the redirect/ack outputs.
//  IN_HANDLER: i_IrqReq ignored (no nesting).
//   i_RetiExec -> o_RedirectPc<=savedPc, o_Redirect=1, o_AckComplete=1, o_InHandler<=0, -> IDLE.
//   o_ActiveIrq is held until this edge, then cleared to 0.
//  i_RetiExec in IDLE or WAIT_BND: o_Err=1 for one cycle; no redirect/ack; state unchanged.
//  Simultaneous events:
//   i_RetiExec with i_IrqReq in IN_HANDLER: return wins; the new request can be accepted at the earliest
//   one cycle later, from IDLE (tail-chain).
//   i_RetiExec with i_InstrBoundary in IDLE: o_Err and accept both occur.
//  i_CoreIntEn affects only entry; clearing it inside a handler has no effect.
// STRUCTURE
//  Shared pkg/header: state encodings (ST_IDLE=2'd0, ST_WAIT_BND=2'd1, ST_IN_HANDLER=2'd2),
//  VECTOR_BASE/VECTOR_STRIDE defaults, IRQ_W.
//  Single module. Optional sub-module irq_vector_calc (combinational base+num*stride) for reuse by the
//  CSR block.
// TESTING
//  T1: IrqReq=1, IrqNumber=2, CoreIntEn=1, InstrBoundary=1, NextPc=0x40 -> next cycle Redirect=1,
//      RedirectPc=0x120, AckAttended=1, InHandler=1, ActiveIrq=2.
//  T2: in handler, RetiExec=1 -> next cycle Redirect=1, RedirectPc=0x40, AckComplete=1, InHandler=0;
//      with IrqReq still high and Boundary=1, next entry occurs 1 cycle later (no AckComplete/AckAttended
//      overlap).
//  T3: IrqReq=1 with no boundary for 3 cycles, then IrqReq=0 -> IDLE, no AckAttended ever pulses.
//  T4: CoreIntEn=0, IrqReq=1, Boundary=1 -> no accept; raise CoreIntEn -> accept at the next boundary.
//  T5: RetiExec=1 in IDLE -> Err=1 for 1 cycle; Redirect=0, AckComplete=0.
//  T6: i_Rst=1 in IN_HANDLER -> all outputs 0 next cycle, no AckComplete; VECTOR_BASE=0xFFFF_FFF0,
//      irq 3 -> RedirectPc=0x0000_0020 (wrap).

Source files
------------

// File: rtl/interrupt_responder_pkg.sv
// Shared definitions for the interrupt responder and its vector calculator.
// Contents: FSM state encoding, default vector-table geometry and widths.
package interrupt_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BND   = 2'd1,
        ST_IN_HANDLER = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W        = 32;
    localparam int unsigned DEF_IRQ_W         = 2;
    localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0100;
    localparam int unsigned DEF_VECTOR_STRIDE = 16;

endpackage

// File: rtl/interrupt_responder_vector_calc.sv
// Combinational vector address: VECTOR_BASE + irq_number * VECTOR_STRIDE,
// wrapping modulo 2^ADDR_W. Kept separate so the CSR block can reuse it.
// Ports:
//   i_IrqNumber  in   IRQ_W    interrupt source number
//   o_Vector     out  ADDR_W   handler entry address
module irq_vector_calc
    import interrupt_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W        = DEF_ADDR_W,
    parameter int unsigned       IRQ_W         = DEF_IRQ_W,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(DEF_VECTOR_BASE),
    parameter int unsigned       VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
    input  logic [IRQ_W-1:0]  i_IrqNumber,
    output logic [ADDR_W-1:0] o_Vector
);

    logic [ADDR_W-1:0] w_Offset;

    // All terms are ADDR_W wide, so the sum wraps naturally.
    assign w_Offset = ADDR_W'(i_IrqNumber) * ADDR_W'(VECTOR_STRIDE);
    assign o_Vector = VECTOR_BASE + w_Offset;

endmodule

// File: rtl/interrupt_responder.sv
// Core-side end of the interrupt request/acknowledge handshake.
// Takes a request at an instruction boundary, saves the return PC, redirects
// fetch to the vector, and redirects back when the return instruction retires.
// Single level, no nesting. All outputs registered; pulses last one cycle.
// Ports:
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_IrqReq           level request from the controller
//   i_IrqNumber        requesting source number
//   i_CoreIntEn        global interrupt enable (gates entry only)
//   i_InstrBoundary    instruction retires this cycle (safe entry point)
//   i_NextPc           PC of the next instruction, valid with i_InstrBoundary
//   i_RetiExec         return-from-interrupt retires this cycle
//   o_AckAttended      pulse on entry
//   o_AckComplete      pulse on return
//   o_Redirect         pulse: fetch loads o_RedirectPc
//   o_RedirectPc       vector on entry, saved PC on return
//   o_InHandler        level: handler running
//   o_ActiveIrq        source being serviced, cleared on return
//   o_Err              pulse: i_RetiExec outside a handler
module interrupt_responder
    import interrupt_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W        = DEF_ADDR_W,
    parameter int unsigned       IRQ_W         = DEF_IRQ_W,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(DEF_VECTOR_BASE),
    parameter int unsigned       VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_IrqReq,
    input  logic [IRQ_W-1:0]  i_IrqNumber,
    input  logic              i_CoreIntEn,
    input  logic              i_InstrBoundary,
    input  logic [ADDR_W-1:0] i_NextPc,
    input  logic              i_RetiExec,
    output logic              o_AckAttended,
    output logic              o_AckComplete,
    output logic              o_Redirect,
    output logic [ADDR_W-1:0] o_RedirectPc,
    output logic              o_InHandler,
    output logic [IRQ_W-1:0]  o_ActiveIrq,
    output logic              o_Err
);

    state_t            r_State;
    state_t            w_NextState;
    logic [ADDR_W-1:0] r_SavedPc;
    logic [ADDR_W-1:0] w_Vector;
    logic              w_Take;
    logic              w_Accept;
    logic              w_Return;
    logic              w_Err;

    irq_vector_calc #(
        .ADDR_W        (ADDR_W),
        .IRQ_W         (IRQ_W),
        .VECTOR_BASE   (VECTOR_BASE),
        .VECTOR_STRIDE (VECTOR_STRIDE)
    ) u_vector_calc (
        .i_IrqNumber (i_IrqNumber),
        .o_Vector    (w_Vector)
    );

    always_comb begin
        w_NextState = r_State;
        w_Accept    = 1'b0;
        w_Return    = 1'b0;
        w_Take      = i_IrqReq & i_CoreIntEn;
        unique case (r_State)
            ST_IDLE: begin
                if (w_Take) begin
                    if (i_InstrBoundary) begin
                        w_Accept    = 1'b1;
                        w_NextState = ST_IN_HANDLER;
                    end else begin
                        w_NextState = ST_WAIT_BND;
                    end
                end
            end
            ST_WAIT_BND: begin
                // Withdrawn request or disabled core drops back silently.
                if (!w_Take) begin
                    w_NextState = ST_IDLE;
                end else if (i_InstrBoundary) begin
                    w_Accept    = 1'b1;
                    w_NextState = ST_IN_HANDLER;
                end
            end
            ST_IN_HANDLER: begin
                // Requests are ignored here; a pending one tail-chains from IDLE.
                if (i_RetiExec) begin
                    w_Return    = 1'b1;
                    w_NextState = ST_IDLE;
                end
            end
            default: w_NextState = ST_IDLE;
        endcase
        // Stray return is flagged independently of any entry on the same edge.
        w_Err = i_RetiExec & (r_State != ST_IN_HANDLER);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State       <= ST_IDLE;
            r_SavedPc     <= '0;
            o_AckAttended <= 1'b0;
            o_AckComplete <= 1'b0;
            o_Redirect    <= 1'b0;
            o_RedirectPc  <= '0;
            o_InHandler   <= 1'b0;
            o_ActiveIrq   <= '0;
            o_Err         <= 1'b0;
        end else begin
            r_State       <= w_NextState;
            o_AckAttended <= w_Accept;
            o_AckComplete <= w_Return;
            o_Redirect    <= w_Accept | w_Return;
            o_Err         <= w_Err;
            if (w_Accept) begin
                r_SavedPc    <= i_NextPc;
                o_RedirectPc <= w_Vector;
                o_ActiveIrq  <= i_IrqNumber;
                o_InHandler  <= 1'b1;
            end else if (w_Return) begin
                o_RedirectPc <= r_SavedPc;
                o_ActiveIrq  <= '0;
                o_InHandler  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_responder.sv
module tb_interrupt_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  num;
    logic        en;
    logic        bnd;
    logic [31:0] npc;
    logic        reti;

    logic        a_att, a_cmp, a_red, a_inh, a_err;
    logic [31:0] a_pc;
    logic [1:0]  a_act;
    logic        b_att, b_cmp, b_red, b_inh, b_err;
    logic [31:0] b_pc;
    logic [1:0]  b_act;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: only "is a handler running" and the return address matter.
    bit          m_inh;
    logic [31:0] m_saved;
    logic        e_att, e_cmp, e_red, e_inh, e_err;
    logic [1:0]  e_act;
    logic [31:0] e_pc, e_pc2;

    always #5 clk = ~clk;

    interrupt_responder dut (
        .i_Clk(clk), .i_Rst(rst), .i_IrqReq(req), .i_IrqNumber(num),
        .i_CoreIntEn(en), .i_InstrBoundary(bnd), .i_NextPc(npc), .i_RetiExec(reti),
        .o_AckAttended(a_att), .o_AckComplete(a_cmp), .o_Redirect(a_red),
        .o_RedirectPc(a_pc), .o_InHandler(a_inh), .o_ActiveIrq(a_act), .o_Err(a_err)
    );

    interrupt_responder #(.VECTOR_BASE(32'hFFFF_FFF0)) dut_wrap (
        .i_Clk(clk), .i_Rst(rst), .i_IrqReq(req), .i_IrqNumber(num),
        .i_CoreIntEn(en), .i_InstrBoundary(bnd), .i_NextPc(npc), .i_RetiExec(reti),
        .o_AckAttended(b_att), .o_AckComplete(b_cmp), .o_Redirect(b_red),
        .o_RedirectPc(b_pc), .o_InHandler(b_inh), .o_ActiveIrq(b_act), .o_Err(b_err)
    );

    function automatic logic [6:0] got_a();
        return {a_att, a_cmp, a_red, a_inh, a_act, a_err};
    endfunction

    function automatic logic [6:0] got_b();
        return {b_att, b_cmp, b_red, b_inh, b_act, b_err};
    endfunction

    function automatic logic [6:0] exp_ctl();
        return {e_att, e_cmp, e_red, e_inh, e_act, e_err};
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        bit acc, ret;
        @(posedge clk);
        if (rst) begin
            m_inh = 0; m_saved = '0;
            e_att = 0; e_cmp = 0; e_red = 0; e_inh = 0; e_act = '0; e_err = 0;
            e_pc = '0; e_pc2 = '0;
        end else begin
            acc   = !m_inh && req && en && bnd;
            ret   = m_inh && reti;
            e_err = !m_inh && reti;
            e_att = acc;
            e_cmp = ret;
            e_red = acc || ret;
            if (acc) begin
                e_pc    = 32'h0000_0100 + 32'(num) * 32'd16;
                e_pc2   = 32'hFFFF_FFF0 + 32'(num) * 32'd16;
                m_saved = npc;
                e_act   = num;
                m_inh   = 1;
            end else if (ret) begin
                e_pc  = m_saved;
                e_pc2 = m_saved;
                e_act = '0;
                m_inh = 0;
            end
            e_inh = m_inh;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req = 0; num = 0; en = 1; bnd = 0; npc = '0; reti = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        tick(); tick();
        n_checks++;
        if ({got_a(), a_pc} !== 39'd0)
            $display("FAIL reset_a got=%h exp=0", {got_a(), a_pc});
        else n_pass++;
        n_checks++;
        if ({got_b(), b_pc} !== 39'd0)
            $display("FAIL reset_b got=%h exp=0", {got_b(), b_pc});
        else n_pass++;
        rst = 0; tick();
    endtask

    // T1 entry followed by T2 return with a tail-chained second entry.
    task automatic test_entry_return_tailchain();
        req = 1; num = 2; en = 1; bnd = 1; npc = 32'h40;
        tick();
        req = 0; bnd = 0;
        n_checks++;
        if ({a_red, a_att, a_inh, a_act, a_cmp} !== 6'b111_10_0)
            $display("FAIL entry_ctl got=%b exp=111100", {a_red, a_att, a_inh, a_act, a_cmp});
        else n_pass++;
        n_checks++;
        if (a_pc !== 32'h120) $display("FAIL entry_pc got=%h exp=00000120", a_pc);
        else n_pass++;
        tick();
        n_checks++;
        if ({a_red, a_att, a_inh} !== 3'b001)
            $display("FAIL entry_pulse_width got=%b exp=001", {a_red, a_att, a_inh});
        else n_pass++;
        reti = 1; req = 1; num = 1; bnd = 1; npc = 32'h200;
        tick();
        reti = 0;
        n_checks++;
        if ({a_red, a_cmp, a_att, a_inh, a_act} !== 6'b110_0_00)
            $display("FAIL return_ctl got=%b exp=110000", {a_red, a_cmp, a_att, a_inh, a_act});
        else n_pass++;
        n_checks++;
        if (a_pc !== 32'h40) $display("FAIL return_pc got=%h exp=00000040", a_pc);
        else n_pass++;
        tick();
        req = 0; bnd = 0;
        n_checks++;
        if ({a_att, a_cmp, a_inh, a_act} !== 5'b1_0_1_01 || a_pc !== 32'h110)
            $display("FAIL tailchain got=%b pc=%h exp=10101 pc=00000110", {a_att, a_cmp, a_inh, a_act}, a_pc);
        else n_pass++;
        reti = 1; tick(); reti = 0; tick();
    endtask

    // T3: request withdrawn before any boundary.
    task automatic test_withdraw();
        int seen = 0;
        req = 1; num = 3; en = 1; bnd = 0;
        for (int i = 0; i < 3; i++) begin tick(); seen += int'(a_att); end
        req = 0; tick(); seen += int'(a_att);
        bnd = 1; tick(); seen += int'(a_att);
        tick(); seen += int'(a_att);
        bnd = 0;
        n_checks++;
        if (seen != 0 || a_inh !== 1'b0)
            $display("FAIL withdraw got_acks=%0d inh=%b exp=0 0", seen, a_inh);
        else n_pass++;
    endtask

    // T4: entry gated by core interrupt enable.
    task automatic test_int_enable();
        en = 0; req = 1; num = 0; bnd = 1; npc = 32'h1234;
        tick(); tick();
        n_checks++;
        if ({a_att, a_inh} !== 2'b00) $display("FAIL inten_blocked got=%b exp=00", {a_att, a_inh});
        else n_pass++;
        en = 1; bnd = 0; tick();
        n_checks++;
        if ({a_att, a_inh} !== 2'b00) $display("FAIL inten_noboundary got=%b exp=00", {a_att, a_inh});
        else n_pass++;
        bnd = 1; tick();
        req = 0; bnd = 0;
        n_checks++;
        if ({a_att, a_inh, a_pc} !== {2'b11, 32'h100})
            $display("FAIL inten_accept got=%b pc=%h exp=11 pc=00000100", {a_att, a_inh}, a_pc);
        else n_pass++;
        en = 0; tick();
        n_checks++;
        if (a_inh !== 1'b1) $display("FAIL inten_clear_in_handler got=%b exp=1", a_inh);
        else n_pass++;
        reti = 1; tick(); reti = 0; en = 1;
        n_checks++;
        if ({a_cmp, a_pc} !== {1'b1, 32'h1234})
            $display("FAIL inten_return got=%b pc=%h exp=1 pc=00001234", a_cmp, a_pc);
        else n_pass++;
        tick();
    endtask

    // T5: stray return, alone and coincident with an entry.
    task automatic test_err();
        reti = 1; tick(); reti = 0;
        n_checks++;
        if ({a_err, a_red, a_cmp} !== 3'b100) $display("FAIL err_idle got=%b exp=100", {a_err, a_red, a_cmp});
        else n_pass++;
        tick();
        n_checks++;
        if (a_err !== 1'b0) $display("FAIL err_width got=%b exp=0", a_err);
        else n_pass++;
        reti = 1; req = 1; num = 2; bnd = 1; npc = 32'h88;
        tick(); reti = 0; req = 0; bnd = 0;
        n_checks++;
        if ({a_err, a_att, a_cmp, a_pc} !== {3'b110, 32'h120})
            $display("FAIL err_with_accept got=%b pc=%h exp=110 pc=00000120", {a_err, a_att, a_cmp}, a_pc);
        else n_pass++;
        reti = 1; tick(); reti = 0; tick();
    endtask

    // T6: reset inside a handler, and vector wrap on the high-base instance.
    task automatic test_reset_mid_handler();
        req = 1; num = 3; bnd = 1; npc = 32'h500;
        tick(); req = 0; bnd = 0;
        n_checks++;
        if ({b_att, b_pc} !== {1'b1, 32'h0000_0020})
            $display("FAIL wrap_pc got=%b pc=%h exp=1 pc=00000020", b_att, b_pc);
        else n_pass++;
        rst = 1; reti = 1; tick(); rst = 0; reti = 0;
        n_checks++;
        if ({got_a(), a_pc} !== 39'd0) $display("FAIL rst_in_handler got=%h exp=0", {got_a(), a_pc});
        else n_pass++;
        reti = 1; tick(); reti = 0;
        n_checks++;
        if ({a_err, a_cmp, a_red} !== 3'b100)
            $display("FAIL rst_discards_context got=%b exp=100", {a_err, a_cmp, a_red});
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst  = ($urandom_range(0, 59) == 0);
            req  = ($urandom_range(0, 2) != 0);
            num  = 2'($urandom);
            en   = ($urandom_range(0, 3) != 0);
            bnd  = $urandom_range(0, 1) == 1;
            npc  = $urandom;
            reti = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (got_a() !== exp_ctl() || got_b() !== exp_ctl())
                $display("FAIL rand_ctl cyc=%0d got=%b/%b exp=%b", cyc, got_a(), got_b(), exp_ctl());
            else n_pass++;
            if (e_red) begin
                n_checks++;
                if (a_pc !== e_pc || b_pc !== e_pc2)
                    $display("FAIL rand_pc cyc=%0d got=%h/%h exp=%h/%h", cyc, a_pc, b_pc, e_pc, e_pc2);
                else n_pass++;
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_entry_return_tailchain();
        test_withdraw();
        test_int_enable();
        test_err();
        test_reset_mid_handler();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
